// File: rtl/axi_burst_master.sv
// axi_burst_master
//   AXI-style bus master with two independent engines. The read engine issues
//   one AR request and collects R beats into a flat buffer. The write engine
//   latches a flat buffer, then issues AW, streams W beats and waits for B.
//   Each engine reports busy, a one-cycle done pulse and a status value.
//
// Ports (CMDW = ADDR_W+LEN_W+ID_W, commands packed {addr,len,id})
//   clk, rst                     clock, asynchronous active-low reset
//   rd_start, rd_cmd             launch a read burst (taken only when idle)
//   rd_busy, rd_done, rd_err     read status; rd_err is valid with rd_done
//   rd_buf                       read data, beat k at [k*DATA_W +: DATA_W]
//   wr_start, wr_cmd, wr_buf     launch a write burst (taken only when idle)
//   wr_busy, wr_done, wr_bresp   write status; wr_bresp is valid with wr_done
//   AR*/R*                       read address and read data channels
//   AW*/W*/B*                    write address, write data, write response
module axi_burst_master #(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 8,
    parameter  int ID_W   = 4,
    parameter  int LEN_W  = 4,
    parameter  int RESP_W = 2,
    localparam int MAXB   = 2**LEN_W,
    localparam int CMDW   = ADDR_W + LEN_W + ID_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_start,
    input  logic [CMDW-1:0]          rd_cmd,
    output logic                     rd_busy,
    output logic                     rd_done,
    output logic                     rd_err,
    output logic [MAXB*DATA_W-1:0]   rd_buf,
    input  logic                     wr_start,
    input  logic [CMDW-1:0]          wr_cmd,
    input  logic [MAXB*DATA_W-1:0]   wr_buf,
    output logic                     wr_busy,
    output logic                     wr_done,
    output logic [RESP_W-1:0]        wr_bresp,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    output logic [ADDR_W-1:0]        ARADDR,
    output logic [LEN_W-1:0]         ARLEN,
    output logic [ID_W-1:0]          ARID,
    input  logic                     RVALID,
    output logic                     RREADY,
    input  logic [DATA_W-1:0]        RDATA,
    input  logic [RESP_W-1:0]        RRESP,
    input  logic                     RLAST,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [ADDR_W-1:0]        AWADDR,
    output logic [LEN_W-1:0]         AWLEN,
    output logic [ID_W-1:0]          AWID,
    output logic                     WVALID,
    input  logic                     WREADY,
    output logic [DATA_W-1:0]        WDATA,
    output logic                     WLAST,
    input  logic                     BVALID,
    output logic                     BREADY,
    input  logic [RESP_W-1:0]        BRESP
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    // ---------------- read engine ----------------
    rstate_t             r_state, r_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [ID_W-1:0]     r_id;
    logic [LEN_W:0]      r_cnt;   // one extra bit so a full-length burst never wraps
    logic                r_beat;
    logic                r_at_len;
    logic                r_end;

    assign r_beat   = RVALID && RREADY;
    assign r_at_len = (r_cnt == {1'b0, r_len});
    // A burst ends on RLAST or on the last expected beat, whichever comes first.
    assign r_end    = r_beat && (RLAST || r_at_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rd_start) r_next = R_ADDR;
            R_ADDR:  if (ARREADY)  r_next = R_DATA;
            R_DATA:  if (r_end)    r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign rd_busy = (r_state != R_IDLE);
    assign ARVALID = (r_state == R_ADDR);
    assign RREADY  = (r_state == R_DATA);
    assign ARADDR  = ARVALID ? r_addr : '0;
    assign ARLEN   = ARVALID ? r_len  : '0;
    assign ARID    = ARVALID ? r_id   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            rd_buf  <= '0;
            rd_err  <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (r_state == R_IDLE && rd_start) begin
                r_addr <= rd_cmd[CMDW-1 -: ADDR_W];
                r_len  <= rd_cmd[ID_W +: LEN_W];
                r_id   <= rd_cmd[ID_W-1:0];
                r_cnt  <= '0;
                rd_buf <= '0;
                rd_err <= 1'b0;
            end
            if (r_beat) begin
                for (int k = 0; k < MAXB; k++) begin
                    if (r_cnt[LEN_W-1:0] == LEN_W'(k))
                        rd_buf[k*DATA_W +: DATA_W] <= RDATA;
                end
                r_cnt <= r_cnt + (LEN_W+1)'(1);
                // Sticky: slave error, early RLAST, or missing RLAST on the last beat.
                if ((RRESP != '0) || (RLAST != r_at_len))
                    rd_err <= 1'b1;
                if (r_end)
                    rd_done <= 1'b1;
            end
        end
    end

    // ---------------- write engine ----------------
    wstate_t             w_state, w_next;
    logic [ADDR_W-1:0]   w_addr;
    logic [LEN_W-1:0]    w_len;
    logic [ID_W-1:0]     w_id;
    logic [MAXB*DATA_W-1:0] w_buf;
    logic [LEN_W:0]      w_cnt;
    logic                w_at_len;
    logic                w_beat;
    logic [DATA_W-1:0]   w_slot;

    assign w_at_len = (w_cnt == {1'b0, w_len});
    assign w_beat   = WVALID && WREADY;

    always_comb begin
        w_slot = '0;
        for (int k = 0; k < MAXB; k++) begin
            if (w_cnt[LEN_W-1:0] == LEN_W'(k))
                w_slot = w_buf[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (wr_start)            w_next = W_ADDR;
            W_ADDR:  if (AWREADY)             w_next = W_DATA;
            W_DATA:  if (w_beat && w_at_len)  w_next = W_RESP;
            W_RESP:  if (BVALID)              w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    assign wr_busy = (w_state != W_IDLE);
    assign AWVALID = (w_state == W_ADDR);
    assign WVALID  = (w_state == W_DATA);
    assign BREADY  = (w_state == W_RESP);
    assign AWADDR  = AWVALID ? w_addr : '0;
    assign AWLEN   = AWVALID ? w_len  : '0;
    assign AWID    = AWVALID ? w_id   : '0;
    assign WDATA   = WVALID  ? w_slot : '0;
    assign WLAST   = WVALID && w_at_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_addr   <= '0;
            w_len    <= '0;
            w_id     <= '0;
            w_buf    <= '0;
            w_cnt    <= '0;
            wr_bresp <= '0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            if (w_state == W_IDLE && wr_start) begin
                w_addr <= wr_cmd[CMDW-1 -: ADDR_W];
                w_len  <= wr_cmd[ID_W +: LEN_W];
                w_id   <= wr_cmd[ID_W-1:0];
                w_buf  <= wr_buf;   // snapshot: later wr_buf changes do not matter
                w_cnt  <= '0;
            end
            if (w_beat && !w_at_len)
                w_cnt <= w_cnt + (LEN_W+1)'(1);
            if (w_state == W_RESP && BVALID) begin
                wr_bresp <= BRESP;
                wr_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_start = 1'b0;
    logic [15:0]  rd_cmd = '0;
    logic         rd_busy, rd_done, rd_err;
    logic [127:0] rd_buf;
    logic         wr_start = 1'b0;
    logic [15:0]  wr_cmd = '0;
    logic [127:0] wr_buf = '0;
    logic         wr_busy, wr_done;
    logic [1:0]   wr_bresp;
    logic         ARVALID, ARREADY = 1'b0;
    logic [7:0]   ARADDR;
    logic [3:0]   ARLEN, ARID;
    logic         RVALID = 1'b0, RREADY, RLAST = 1'b0;
    logic [7:0]   RDATA = '0;
    logic [1:0]   RRESP = '0;
    logic         AWVALID, AWREADY = 1'b0;
    logic [7:0]   AWADDR;
    logic [3:0]   AWLEN, AWID;
    logic         WVALID, WREADY = 1'b0, WLAST;
    logic [7:0]   WDATA;
    logic         BVALID = 1'b0, BREADY;
    logic [1:0]   BRESP = '0;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .rd_start(rd_start), .rd_cmd(rd_cmd), .rd_busy(rd_busy), .rd_done(rd_done),
        .rd_err(rd_err), .rd_buf(rd_buf),
        .wr_start(wr_start), .wr_cmd(wr_cmd), .wr_buf(wr_buf), .wr_busy(wr_busy),
        .wr_done(wr_done), .wr_bresp(wr_bresp),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the bus and status outputs must show.
    logic [7:0]   exp_ar_addr, exp_aw_addr;
    logic [3:0]   exp_ar_len, exp_ar_id, exp_aw_len, exp_aw_id;
    logic [127:0] exp_rd_buf;
    logic         exp_rd_err;
    int           exp_rd_n;
    logic [7:0]   exp_w [16];
    int           exp_w_len;
    logic [1:0]   exp_bresp;

    // Read slave script.
    logic [7:0]   rd_data [16];
    logic [1:0]   rd_resp [16];
    int           rd_lastpos;

    // Observed by the compare process.
    int w_idx = 0;
    int rd_done_cnt = 0;
    int wr_done_cnt = 0;
    int wr_done_cyc = 0;
    int wr_start_cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Compare process: every falling edge, bus outputs against the model.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) w_idx = 0;
            if (ARVALID) begin
                chk("araddr", ARADDR, exp_ar_addr);
                chk("arlen", ARLEN, exp_ar_len);
                chk("arid", ARID, exp_ar_id);
            end else chk("ar_idle_zero", {ARADDR, ARLEN, ARID}, '0);
            if (AWVALID) begin
                chk("awaddr", AWADDR, exp_aw_addr);
                chk("awlen", AWLEN, exp_aw_len);
                chk("awid", AWID, exp_aw_id);
            end else chk("aw_idle_zero", {AWADDR, AWLEN, AWID}, '0);
            if (WVALID && WREADY) begin
                if (w_idx > exp_w_len) chk("w_extra_beat", w_idx, exp_w_len);
                else begin
                    chk("wdata", WDATA, exp_w[w_idx]);
                    chk("wlast", WLAST, (w_idx == exp_w_len));
                end
                w_idx++;
            end else if (!WVALID) chk("w_idle_zero", {WDATA, WLAST}, '0);
            if (rd_done) begin
                chk("rd_buf", rd_buf, exp_rd_buf);
                chk("rd_err", rd_err, exp_rd_err);
                rd_done_cnt++;
            end
            if (wr_done) begin
                chk("wr_bresp", wr_bresp, exp_bresp);
                chk("w_beat_count", w_idx, exp_w_len + 1);
                w_idx = 0;
                wr_done_cnt++;
                wr_done_cyc = cyc;
            end
        end
    endtask

    // Called at posedge+#1.
    task automatic start_rd(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id);
        exp_ar_addr = a; exp_ar_len = l; exp_ar_id = id;
        exp_rd_n   = (rd_lastpos < int'(l)) ? rd_lastpos + 1 : int'(l) + 1;
        exp_rd_err = (rd_lastpos != int'(l));
        exp_rd_buf = '0;
        for (int k = 0; k < exp_rd_n; k++) begin
            exp_rd_buf[k*8 +: 8] = rd_data[k];
            if (rd_resp[k] != 2'd0) exp_rd_err = 1'b1;
        end
        rd_cmd = {a, l, id};
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic start_wr(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id,
                            input logic [127:0] b, input logic [1:0] br);
        exp_aw_addr = a; exp_aw_len = l; exp_aw_id = id;
        exp_w_len = int'(l);
        exp_bresp = br;
        for (int k = 0; k < 16; k++) exp_w[k] = b[k*8 +: 8];
        wr_cmd = {a, l, id};
        wr_buf = b;
        wr_start = 1'b1;
        wr_start_cyc = cyc;
        @(posedge clk); #1;
        wr_start = 1'b0;
    endtask

    task automatic rd_slave(input int ar_wait, input int rgap);
        int g;
        ARREADY = (ar_wait == 0);
        g = 0;
        do begin @(negedge clk); g++; end while (!ARVALID && g < 100);
        if (!ARVALID) begin timeout("ar_handshake"); ARREADY = 1'b0; return; end
        if (ar_wait > 0) begin
            repeat (ar_wait) begin @(posedge clk); #1; end
            ARREADY = 1'b1;
        end
        @(posedge clk); #1;
        ARREADY = 1'b0;
        for (int k = 0; k < exp_rd_n; k++) begin
            RVALID = 1'b1; RDATA = rd_data[k]; RRESP = rd_resp[k]; RLAST = (k == rd_lastpos);
            g = 0;
            do begin @(negedge clk); g++; end while (!RREADY && g < 100);
            if (!RREADY) begin
                timeout("r_handshake");
                RVALID = 1'b0; RLAST = 1'b0;
                return;
            end
            @(posedge clk); #1;
            RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = '0;
            repeat (rgap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wr_slave(input int aw_wait, input bit wtog, input logic [1:0] br);
        int  g;
        logic ph;
        AWREADY = (aw_wait == 0);
        g = 0;
        do begin @(negedge clk); g++; end while (!AWVALID && g < 100);
        if (!AWVALID) begin timeout("aw_handshake"); AWREADY = 1'b0; return; end
        if (aw_wait > 0) begin
            repeat (aw_wait) begin @(posedge clk); #1; end
            AWREADY = 1'b1;
        end
        @(posedge clk); #1;
        AWREADY = 1'b0;
        ph = 1'b0;
        g = 0;
        forever begin
            WREADY = wtog ? ph : 1'b1;
            ph = ~ph;
            @(negedge clk);
            if (WVALID && WREADY && WLAST) break;
            g++;
            if (g > 100) begin timeout("w_handshake"); WREADY = 1'b0; return; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        WREADY = 1'b0;
        BVALID = 1'b1; BRESP = br;
        g = 0;
        do begin @(negedge clk); g++; end while (!BREADY && g < 100);
        if (!BREADY) timeout("b_handshake");
        @(posedge clk); #1;
        BVALID = 1'b0; BRESP = '0;
    endtask

    task automatic set_rd(input logic [7:0] base, input int lastpos);
        for (int k = 0; k < 16; k++) begin
            rd_data[k] = base + 8'(k);
            rd_resp[k] = 2'd0;
        end
        rd_lastpos = lastpos;
    endtask

    initial begin
        logic [127:0] b;
        int r0, w0;

        exp_ar_addr = '0; exp_ar_len = '0; exp_ar_id = '0;
        exp_aw_addr = '0; exp_aw_len = '0; exp_aw_id = '0;
        exp_rd_buf = '0; exp_rd_err = 1'b0; exp_rd_n = 0; exp_w_len = 0; exp_bresp = '0;
        for (int k = 0; k < 16; k++) exp_w[k] = '0;
        set_rd(8'h00, 0);

        fork
            monitor();
            begin
                #400000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1);
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {rd_busy, rd_done, rd_err, wr_busy, wr_done, wr_bresp, ARVALID, RREADY,
             AWVALID, WVALID, BREADY}, '0);
        chk("reset_rd_buf", rd_buf, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Read len=3, ARREADY delayed 2 cycles
        set_rd(8'h11, 3);
        rd_data[0] = 8'h11; rd_data[1] = 8'h22; rd_data[2] = 8'h33; rd_data[3] = 8'h44;
        start_rd(8'h40, 4'd3, 4'd5);
        rd_slave(2, 0);
        repeat (2) @(posedge clk); #1;
        chk("t1_rd_buf_lo", rd_buf[31:0], 32'h44332211);
        chk("t1_rd_buf_hi", rd_buf[127:32], '0);
        chk("t1_rd_err", rd_err, 1'b0);
        chk("t1_done_count", rd_done_cnt, 1);

        // Single-beat write, zero-wait slave
        b = '0; b[7:0] = 8'hA5;
        start_wr(8'h10, 4'd0, 4'd2, b, 2'd0);
        wr_slave(0, 1'b0, 2'd0);
        repeat (2) @(posedge clk); #1;
        chk("t2_latency", wr_done_cyc - wr_start_cyc, 4);
        chk("t2_bresp", wr_bresp, 2'd0);
        chk("t2_done_count", wr_done_cnt, 1);

        // Max-length write, WREADY toggling, BRESP=2
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'(k * 17);
        start_wr(8'hC0, 4'd15, 4'd9, b, 2'd2);
        wr_slave(1, 1'b1, 2'd2);
        repeat (2) @(posedge clk); #1;
        chk("t3_bresp", wr_bresp, 2'd2);
        chk("t3_done_count", wr_done_cnt, 2);

        // Read with early RLAST on beat 1
        set_rd(8'h11, 1);
        rd_data[0] = 8'h11; rd_data[1] = 8'h22;
        start_rd(8'h50, 4'd3, 4'd1);
        rd_slave(0, 0);
        repeat (2) @(posedge clk); #1;
        chk("t4a_rd_err", rd_err, 1'b1);
        chk("t4a_rd_buf", rd_buf, 128'h2211);
        chk("t4a_busy", rd_busy, 1'b0);

        // Read with RRESP=2 on beat 2
        set_rd(8'h61, 3);
        rd_resp[2] = 2'd2;
        start_rd(8'h54, 4'd3, 4'd6);
        rd_slave(0, 1);
        repeat (2) @(posedge clk); #1;
        chk("t4b_rd_err", rd_err, 1'b1);
        chk("t4b_rd_buf", rd_buf, 128'h64636261);

        // Concurrent read and write, starts while busy
        r0 = rd_done_cnt; w0 = wr_done_cnt;
        set_rd(8'hA1, 3);
        b = '0;
        for (int k = 0; k < 4; k++) b[k*8 +: 8] = 8'hC0 + 8'(k);
        fork
            begin start_rd(8'h80, 4'd3, 4'd9); rd_slave(1, 1); end
            begin start_wr(8'h30, 4'd3, 4'd7, b, 2'd1); wr_slave(2, 1'b1, 2'd1); end
            begin
                repeat (4) @(posedge clk); #1;
                rd_cmd = 16'hFFFF; wr_cmd = 16'hEEEE; wr_buf = {16{8'h5A}};
                rd_start = 1'b1; wr_start = 1'b1;
                @(posedge clk); #1;
                rd_start = 1'b0; wr_start = 1'b0;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("t5_rd_buf", rd_buf[31:0], 32'hA4A3A2A1);
        chk("t5_rd_err", rd_err, 1'b0);
        chk("t5_bresp", wr_bresp, 2'd1);
        chk("t5_rd_done_once", rd_done_cnt - r0, 1);
        chk("t5_wr_done_once", wr_done_cnt - w0, 1);
        chk("t5_both_idle", {rd_busy, wr_busy, ARVALID, AWVALID}, '0);

        // Reset in the middle of a write burst
        w0 = wr_done_cnt;
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = 8'h70 + 8'(k);
        start_wr(8'h20, 4'd7, 4'd3, b, 2'd0);
        AWREADY = 1'b1; WREADY = 1'b1;
        @(posedge clk); #1;
        AWREADY = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("t6_beat2_presented", WDATA, 8'h72);
        rst = 1'b0;
        #1;
        chk("t6_async_clear",
            {wr_busy, wr_done, AWVALID, WVALID, WLAST, WDATA, BREADY, rd_busy}, '0);
        WREADY = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t6_no_done", wr_done_cnt, w0);
        chk("t6_idle", {wr_busy, wr_bresp}, '0);

        // Fresh write afterwards
        b = '0; b[15:0] = 16'hBEEF;
        start_wr(8'h24, 4'd1, 4'd4, b, 2'd3);
        wr_slave(0, 1'b0, 2'd3);
        repeat (2) @(posedge clk); #1;
        chk("t7_done_count", wr_done_cnt, w0 + 1);
        chk("t7_bresp", wr_bresp, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
